// File: rtl/piso_stream.sv
// Parametrised parallel-in/serial-out shifter with a valid/ready load handshake,
// run-time bit order per word, and valid/last framing on the serial output.
module piso_stream #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [DW-1:0] din,
    input  logic          msb_first,
    output logic          sout,
    output logic          sout_valid,
    output logic          sout_last
);

    localparam int CNT_W = $clog2(DW);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   shreg, shreg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic            mode, mode_nxt;
    logic            at_last;
    logic            accept;

    assign at_last = (cnt == CNT_W'(DW - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            mode  <= 1'b1;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            mode  <= mode_nxt;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case/if tree can infer a latch.
    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        cnt_nxt    = cnt;
        mode_nxt   = mode;
        load_ready = 1'b0;

        sout_valid = rst && (state == SHIFT);
        sout_last  = sout_valid && at_last;
        sout       = sout_valid && (mode ? shreg[DW-1] : shreg[0]);

        case (state)
            IDLE:    load_ready = rst;
            SHIFT:   load_ready = rst && enb && at_last;
            default: load_ready = 1'b0;
        endcase

        accept = load_valid && load_ready;

        if (accept) begin
            // A reload on the last bit keeps the link gapless.
            state_nxt = SHIFT;
            shreg_nxt = din;
            mode_nxt  = msb_first;
            cnt_nxt   = '0;
        end else if (state == SHIFT && enb) begin
            if (at_last) begin
                state_nxt = IDLE;
                shreg_nxt = '0;
            end else begin
                shreg_nxt = mode ? {shreg[DW-2:0], 1'b0} : {1'b0, shreg[DW-1:1]};
                cnt_nxt   = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: a per-cycle vector table on an 8-bit instance
// plus a hand-written abort/reload sequence on a 4-bit instance.
module tb_piso_stream;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       rst = 1'b0, enb = 1'b0, load_valid = 1'b0, msb_first = 1'b1;
    logic [7:0] din = '0;
    logic       load_ready, sout, sout_valid, sout_last;

    // 4-bit instance
    logic       rst_4 = 1'b0, enb_4 = 1'b0, load_valid_4 = 1'b0, msb_first_4 = 1'b1;
    logic [3:0] din_4 = '0;
    logic       load_ready_4, sout_4, sout_valid_4, sout_last_4;

    piso_stream #(.DW(8)) dut (
        .clk(clk), .rst(rst), .enb(enb), .load_valid(load_valid),
        .load_ready(load_ready), .din(din), .msb_first(msb_first),
        .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last)
    );

    piso_stream #(.DW(4)) dut_4 (
        .clk(clk), .rst(rst_4), .enb(enb_4), .load_valid(load_valid_4),
        .load_ready(load_ready_4), .din(din_4), .msb_first(msb_first_4),
        .sout(sout_4), .sout_valid(sout_valid_4), .sout_last(sout_last_4)
    );

    // Expected outputs are packed as {load_ready, sout, sout_valid, sout_last}.
    typedef struct {
        logic       rst;
        logic       enb;
        logic       lv;
        logic [7:0] din;
        logic       msb;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got rdy/sout/vld/last=%b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input string name, input logic r, input logic e, input logic lv,
                       input logic [7:0] d, input logic m, input logic [3:0] exp);
        vec_t v;
        v.rst = r; v.enb = e; v.lv = lv; v.din = d; v.msb = m; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // One cycle on the DW=4 instance: drive after the edge, check mid-cycle.
    task automatic cyc_4(input string name, input logic r, input logic e, input logic lv,
                         input logic [3:0] d, input logic m, input logic [3:0] exp);
        @(posedge clk);
        #1;
        rst_4 = r; enb_4 = e; load_valid_4 = lv; din_4 = d; msb_first_4 = m;
        @(negedge clk);
        check(name, {load_ready_4, sout_4, sout_valid_4, sout_last_4}, exp);
    endtask

    initial begin
        logic [7:0] seq;
        logic [7:0] seq_b;

        // Reset held with a pending offer: nothing visible, nothing captured.
        add("rst_0", 0, 1, 1, 8'hB4, 1, 4'b0000);
        add("rst_1", 0, 1, 1, 8'hB4, 1, 4'b0000);
        add("idle_ready", 1, 1, 0, 8'h00, 1, 4'b1000);

        // MSB-first 8'hB4.
        add("msb_accept", 1, 1, 1, 8'hB4, 1, 4'b1000);
        seq = 8'b1011_0100;
        for (int i = 0; i < 8; i++)
            add($sformatf("msb_bit%0d", i + 1), 1, 1, 0, 8'h00, 1,
                {i == 7, seq[7-i], 1'b1, i == 7});
        add("msb_done", 1, 1, 0, 8'h00, 1, 4'b1000);

        // LSB-first 8'hB4; msb_first toggled mid-frame must not matter.
        add("lsb_accept", 1, 1, 1, 8'hB4, 0, 4'b1000);
        seq = 8'b0010_1101;
        for (int i = 0; i < 8; i++)
            add($sformatf("lsb_bit%0d", i + 1), 1, 1, 0, 8'hFF, 1,
                {i == 7, seq[7-i], 1'b1, i == 7});
        add("lsb_done", 1, 1, 0, 8'h00, 1, 4'b1000);

        // Stall on bit 3 for three cycles while a load is offered (ignored).
        add("stall_accept", 1, 1, 1, 8'hB4, 1, 4'b1000);
        seq = 8'b1011_0100;
        for (int i = 0; i < 2; i++)
            add($sformatf("stall_bit%0d", i + 1), 1, 1, 0, 8'h00, 1, {1'b0, seq[7-i], 2'b10});
        for (int i = 0; i < 3; i++)
            add($sformatf("stall_hold%0d", i), 1, 0, 1, 8'hFF, 0, 4'b0110);
        for (int i = 2; i < 8; i++)
            add($sformatf("stall_bit%0d", i + 1), 1, 1, 0, 8'h00, 1,
                {i == 7, seq[7-i], 1'b1, i == 7});
        add("stall_done", 1, 1, 0, 8'h00, 1, 4'b1000);

        // Back-to-back: 8'hB4 MSB-first, then 8'h5A LSB-first with no bubble.
        add("b2b_accept", 1, 1, 1, 8'hB4, 1, 4'b1000);
        seq   = 8'b1011_0100;
        seq_b = 8'b0101_1010;
        for (int i = 0; i < 8; i++)
            add($sformatf("b2b_w1_bit%0d", i + 1), 1, 1, 1, 8'h5A, 0,
                {i == 7, seq[7-i], 1'b1, i == 7});
        for (int i = 0; i < 8; i++)
            add($sformatf("b2b_w2_bit%0d", i + 1), 1, 1, i == 3, (i == 3) ? 8'hFF : 8'h00, 1,
                {i == 7, seq_b[7-i], 1'b1, i == 7});
        add("b2b_done", 1, 1, 0, 8'h00, 1, 4'b1000);

        foreach (vecs[k]) begin
            if (k != 0) @(posedge clk);
            #1;
            rst = vecs[k].rst; enb = vecs[k].enb; load_valid = vecs[k].lv;
            din = vecs[k].din; msb_first = vecs[k].msb;
            @(negedge clk);
            check(vecs[k].name, {load_ready, sout, sout_valid, sout_last}, vecs[k].exp);
        end

        // DW=4: load 4'hC, abort with reset after three bits, then load 4'h9.
        cyc_4("w4_accept_c", 1, 1, 1, 4'hC, 1, 4'b1000);
        cyc_4("w4_bit1",     1, 1, 0, 4'h0, 1, 4'b0110);
        cyc_4("w4_bit2",     1, 1, 0, 4'h0, 1, 4'b0110);
        cyc_4("w4_bit3",     1, 1, 0, 4'h0, 1, 4'b0010);
        cyc_4("w4_abort",    0, 1, 1, 4'h9, 1, 4'b0000);
        cyc_4("w4_idle",     1, 1, 0, 4'h0, 1, 4'b1000);
        cyc_4("w4_accept_9", 1, 1, 1, 4'h9, 1, 4'b1000);
        cyc_4("w4_9_bit1",   1, 1, 0, 4'h0, 0, 4'b0110);
        cyc_4("w4_9_bit2",   1, 1, 0, 4'h0, 0, 4'b0010);
        cyc_4("w4_9_bit3",   1, 1, 0, 4'h0, 0, 4'b0010);
        cyc_4("w4_9_bit4",   1, 1, 0, 4'h0, 0, 4'b1111);
        cyc_4("w4_9_done",   1, 1, 0, 4'h0, 0, 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
